// File: rtl/ha_array_pkg.sv
// ============================================================================
// Module      : ha_array_pkg
// Description : Shared widths, shifts and FSM state type for the half-adder
//               array accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ha_array_pkg;

    localparam int HA_T_W       = 9;
    localparam int HA_B_W       = 7;
    localparam int HA_B_SHIFT   = 2;
    localparam int HA_ROW_SHIFT = 2;
    localparam int NUM_ARRAYS   = 4;
    localparam int PROD_W       = 16;
    localparam int ACC_W        = 17;
    localparam int VALUE_W      = HA_T_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/ha_array_accumulator_if.sv
// ============================================================================
// Module      : ha_array_accumulator_if
// Description : Row-set input handshake and product output handshake.
//               ovf is present only when HA_ACC_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ha_array_accumulator_if;
    import ha_array_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [HA_T_W-1:0]   ha_array_0_t;
    logic [HA_T_W-1:0]   ha_array_1_t;
    logic [HA_T_W-1:0]   ha_array_2_t;
    logic [HA_T_W-1:0]   ha_array_3_t;
    logic [HA_B_W-1:0]   ha_array_0_b;
    logic [HA_B_W-1:0]   ha_array_1_b;
    logic [HA_B_W-1:0]   ha_array_2_b;
    logic [HA_B_W-1:0]   ha_array_3_b;
    logic                out_valid;
    logic                out_ready;
    logic [PROD_W-1:0]   product;
`ifdef HA_ACC_SAT_EN
    logic                ovf;
`endif

    modport master (
        output in_valid,
        output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
        output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef HA_ACC_SAT_EN
        input  ovf,
`endif
        input  product
    );

    modport slave (
        input  in_valid,
        input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
        input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef HA_ACC_SAT_EN
        output ovf,
`endif
        output product
    );

endinterface

`default_nettype wire

// File: rtl/ha_row_value.sv
// ============================================================================
// Module      : ha_row_value
// Description : Combinational value of one row pair: t + (b << 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_row_value
    import ha_array_pkg::*;
(
    input  wire  [HA_T_W-1:0]  row_t,
    input  wire  [HA_B_W-1:0]  row_b,
    output logic [VALUE_W-1:0] row_value
);

    // b[i] carries weight i+2, so b[6] lines up with t[8]
    assign row_value = VALUE_W'(row_t) + (VALUE_W'(row_b) << HA_B_SHIFT);

endmodule

`default_nettype wire

// File: rtl/ha_array_accumulator.sv
// ============================================================================
// Module      : ha_array_accumulator
// Description : Captures one set of half-adder rows and sums them serially,
//               one array per cycle, into a 16-bit product.
//               Optional saturation/overflow flag: define HA_ACC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_array_accumulator
    import ha_array_pkg::*;
(
    input  wire                   clk,
    input  wire                   rst_n,
    ha_array_accumulator_if.slave bus
);

    acc_state_t          r_state;
    acc_state_t          w_state_next;
    logic                w_load;
    logic                w_add;
    logic                w_done_entry;
    logic                w_done_exit;

    logic [HA_T_W-1:0]   r_t [NUM_ARRAYS];
    logic [HA_B_W-1:0]   r_b [NUM_ARRAYS];
    logic [1:0]          r_idx;
    logic [ACC_W-1:0]    r_acc;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [PROD_W-1:0]   r_product;
`ifdef HA_ACC_SAT_EN
    logic                r_ovf;
`endif

    logic [VALUE_W-1:0]  w_value;
    logic [2:0]          w_shift_amt;
    logic [ACC_W-1:0]    w_acc_next;

    ha_row_value u_row_value (
        .row_t     (r_t[r_idx]),
        .row_b     (r_b[r_idx]),
        .row_value (w_value)
    );

    assign w_shift_amt = 3'(HA_ROW_SHIFT) * {1'b0, r_idx};
    assign w_acc_next  = r_acc + (ACC_W'(w_value) << w_shift_amt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_add        = 1'b0;
        w_done_entry = 1'b0;
        w_done_exit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_load       = 1'b1;
                    w_state_next = ACC;
                end
            end
            ACC: begin
                w_add = 1'b1;
                if (r_idx == 2'd3) begin
                    w_done_entry = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_done_exit  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ARRAYS; k++) begin
                r_t[k] <= '0;
                r_b[k] <= '0;
            end
            r_idx       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
`ifdef HA_ACC_SAT_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            // Registered from the next state so in_ready stays low through reset
            r_in_ready <= (w_state_next == IDLE);

            if (w_load) begin
                r_t[0] <= bus.ha_array_0_t;
                r_t[1] <= bus.ha_array_1_t;
                r_t[2] <= bus.ha_array_2_t;
                r_t[3] <= bus.ha_array_3_t;
                r_b[0] <= bus.ha_array_0_b;
                r_b[1] <= bus.ha_array_1_b;
                r_b[2] <= bus.ha_array_2_b;
                r_b[3] <= bus.ha_array_3_b;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (w_add) begin
                r_acc  <= w_acc_next;
                r_idx  <= r_idx + 2'd1;
            end

            // The last add and the product capture share the DONE-entry edge
            if (w_done_entry) begin
                r_out_valid <= 1'b1;
`ifdef HA_ACC_SAT_EN
                r_product   <= w_acc_next[ACC_W-1] ? {PROD_W{1'b1}} : w_acc_next[PROD_W-1:0];
                r_ovf       <= w_acc_next[ACC_W-1];
`else
                r_product   <= w_acc_next[PROD_W-1:0];
`endif
            end else if (w_done_exit) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.product   = r_product;
`ifdef HA_ACC_SAT_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ha_array_accumulator.sv
// ============================================================================
// Module      : tb_ha_array_accumulator
// Description : Self-checking bench for ha_array_accumulator against an
//               arithmetic row-weighting model (HA_ACC_SAT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ha_array_accumulator;
    import ha_array_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ha_array_accumulator_if bus ();

    ha_array_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [HA_T_W-1:0] st [NUM_ARRAYS];
    logic [HA_B_W-1:0] sb [NUM_ARRAYS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_rows();
        bus.ha_array_0_t = st[0];
        bus.ha_array_1_t = st[1];
        bus.ha_array_2_t = st[2];
        bus.ha_array_3_t = st[3];
        bus.ha_array_0_b = sb[0];
        bus.ha_array_1_b = sb[1];
        bus.ha_array_2_b = sb[2];
        bus.ha_array_3_b = sb[3];
    endtask

    task automatic scramble_bus();
        bus.ha_array_0_t = 9'($urandom);
        bus.ha_array_1_t = 9'($urandom);
        bus.ha_array_2_t = 9'($urandom);
        bus.ha_array_3_t = 9'($urandom);
        bus.ha_array_0_b = 7'($urandom);
        bus.ha_array_1_b = 7'($urandom);
        bus.ha_array_2_b = 7'($urandom);
        bus.ha_array_3_b = 7'($urandom);
    endtask

    task automatic clear_rows();
        for (int k = 0; k < NUM_ARRAYS; k++) begin
            st[k] = '0;
            sb[k] = '0;
        end
    endtask

    // Product = sum over k of (t_k + 4*b_k) * 4^k
    function automatic int ref_sum();
        int s = 0;
        for (int k = 0; k < NUM_ARRAYS; k++)
            s += (int'(st[k]) + 4 * int'(sb[k])) * (4 ** k);
        return s;
    endfunction

    task automatic reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_rst_in_ready"},  32'(bus.in_ready), 0);
        check({tag, "_rst_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_rst_product"},   32'(bus.product), 0);
`ifdef HA_ACC_SAT_EN
        check({tag, "_rst_ovf"},       32'(bus.ovf), 0);
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 1);
        check({tag, "_post_product"},  32'(bus.product), 0);
    endtask

    task automatic wait_accept(input string tag, output bit ok);
        int cyc = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = bus.in_ready;
        if (!ok) begin
            check({tag, "_accept_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble_bus();
        check({tag, "_busy_in_ready"}, 32'(bus.in_ready), 0);
    endtask

    task automatic run_set(input string tag, input int stall);
        int              sum;
        int              cyc;
        bit              ok;
        logic [15:0]     exp_p;
`ifdef HA_ACC_SAT_EN
        logic            exp_o;
`endif
        sum = ref_sum();
`ifdef HA_ACC_SAT_EN
        exp_o = (sum > 65535);
        exp_p = exp_o ? 16'hFFFF : 16'(sum);
`else
        exp_p = 16'(sum % 65536);
`endif
        apply_rows();
        bus.out_ready = (stall == 0);
        wait_accept(tag, ok);
        if (!ok) return;

        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 4);
        check({tag, "_product"}, 32'(bus.product), 32'(exp_p));
`ifdef HA_ACC_SAT_EN
        check({tag, "_ovf"},     32'(bus.ovf), 32'(exp_o));
`endif

        if (stall > 0) begin
            bus.in_valid = 1'b1;
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            check({tag, "_stall_product"},   32'(bus.product), 32'(exp_p));
            check({tag, "_stall_in_ready"},  32'(bus.in_ready), 0);
            check({tag, "_stall_out_valid"}, 32'(bus.out_valid), 1);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        // in_valid may still be high: it must not have been taken on the exit edge
        check({tag, "_exit_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_exit_in_ready"},  32'(bus.in_ready), 1);
        check({tag, "_hold_product"},   32'(bus.product), 32'(exp_p));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_abort(input string tag);
        bit ok;
        bit seen = 1'b0;
        apply_rows();
        bus.out_ready = 1'b1;
        wait_accept(tag, ok);
        if (!ok) return;
        @(posedge clk);
        #1;
        reset_check(tag);
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, "_no_out_valid"}, 32'(seen), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_rows();
        apply_rows();

        reset_check("init");

        clear_rows(); st[0] = 9'd1;
        run_set("single_bit", 0);

        clear_rows(); st[1] = 9'd3; sb[1] = 7'd1;
        run_set("array1", 0);

        clear_rows(); st[3] = 9'd1; sb[3] = 7'd1;
        run_set("top_array", 1);

        for (int k = 0; k < NUM_ARRAYS; k++) begin
            st[k] = 9'h1FF;
            sb[k] = 7'h7F;
        end
        run_set("overflow", 10);

        clear_rows(); st[0] = 9'd5;
        run_set("after_ovf", 0);

        for (int k = 0; k < NUM_ARRAYS; k++) begin
            st[k] = 9'($urandom);
            sb[k] = 7'($urandom);
        end
        run_abort("abort");

        clear_rows(); st[2] = 9'd2;
        run_set("after_abort", 0);

        clear_rows();
        run_set("zero", 2);

        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < NUM_ARRAYS; k++) begin
                st[k] = 9'($urandom);
                sb[k] = 7'($urandom);
            end
            run_set("random", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ha_array_accumulator.md
Name: ha_array_accumulator

Overview:
- Consumer end of the 8x8 approximate-multiplier half-adder-array interface. The generator emits four row pairs, ha_array_k_t[8:0] and ha_array_k_b[6:0] for k=0..3.
- This block captures one set of rows with a valid/ready handshake and sums the rows serially, one array per cycle, into a 16-bit product.
- It presents the product on a valid/ready output. It sits between the combinational generator and the downstream datapath.

Parameters:
- NUM_ARRAYS, 4, number of ha_array row pairs; fixed by the 8x8 generator.
- PROD_W, 16, product output width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  row set present on ha_* inputs.
- in_ready  out  1  block can accept a row set.
- ha_array_0_t .. ha_array_3_t  in  9 each  sum rows.
- ha_array_0_b .. ha_array_3_b  in  7 each  carry rows.
- out_valid  out  1  product available.
- out_ready  in  1  downstream accepts product.
- product  out  PROD_W  accumulated product.
- ovf  out  1  overflow flag; exists only with the optional feature.

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock; rst_n low forces state IDLE, all registers 0, in_ready=0 during reset, out_valid=0, product=0, ovf=0. The first in_ready=1 appears in the first cycle after rst_n deasserts.
- Row weighting:
  - value_k = t_k + (b_k << 2), where b[i] has weight i+2, so b[6] lands at weight 8.
  - Array k is shifted left by 2k, so array 0 has weight 2^0 and array 3 has weight 2^6.
  - Maximum value_k = 511 + 508 = 1019.
- Accumulator is 17 bits internally. The raw sum is at most 1019*85 = 86615, so it can exceed 16 bits.
- FSM states: IDLE, ACC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, register all eight row vectors, clear the accumulator, set idx=0, go to ACC.
  - ACC: in_ready=0. Each cycle, acc += value_idx << (2*idx); idx++. Once idx=3 has been added, go to DONE.
  - DONE: out_valid=1 and product is stable. On out_ready, go to IDLE. out_valid drops the next cycle.
- Latency: handshake at edge E. The four adds occur at edges E+1..E+4. out_valid is high from E+4 and product is valid in the same cycle.
  - Minimum initiation interval is 6 cycles with out_ready tied high.
- Output registering: product and out_valid are registered and change only on DONE entry and exit. product holds its last value in IDLE.
- in_ready is low in ACC and DONE. in_valid pulses there are ignored; the source must hold its data until accepted.
- out_ready asserted outside DONE has no effect.
- A row set that sums to zero still produces out_valid with product=0.
- rst_n asserted mid-ACC or mid-DONE aborts the operation immediately: no output, state returns to IDLE.
- Without the feature, product = acc[15:0], i.e. the sum wraps modulo 2^16.

Optional Feature:
- Macro: HA_ACC_SAT_EN.
- Defined:
  - If acc[16]=1 at DONE entry, product=16'hFFFF and ovf=1; otherwise ovf=0.
  - ovf is registered alongside product and resets to 0.
- Undefined: the ovf port is absent and product wraps as described under Behaviour.

Decomposition:
- Shared package ha_array_pkg holds:
  - constants HA_T_W=9, HA_B_W=7, HA_B_SHIFT=2, HA_ROW_SHIFT=2, NUM_ARRAYS=4, PROD_W=16, ACC_W=17;
  - enum typedef acc_state_t {IDLE, ACC, DONE}.
- One sub-module is natural: ha_row_value. It is combinational, computes t + (b << 2) into 10 bits, and is instantiated once on the row selected by the registered idx mux.

Test Plan:
- Reset and idle: rst_n low mid-run -> in_ready=0, out_valid=0, product=0 during reset. After release, in_ready=1 and product=0 within one cycle.
- Single-bit weight: array0 t=1, all else 0, out_ready=1 -> out_valid at handshake+4, product=0x0001. Array1 t=3, b=1, all else 0 -> product=28 (0x001C).
- Top array: array3 t=0x001, b=0x01, all else 0 -> product=(1+4)<<6=320 (0x0140).
- Overflow: every t=0x1FF and every b=0x7F.
  - Feature off -> product=0x5257 (86615 mod 65536).
  - Feature on -> product=0xFFFF, ovf=1.
  - Next set, array0 t=5 only -> ovf=0.
- Backpressure: out_ready=0 for 10 cycles in DONE -> product stable, in_ready=0. A new in_valid is not accepted until one cycle after out_ready rises.
- Back-to-back with reset: abort with rst_n during ACC -> no out_valid. A following set with array2 t=2 -> product=0x0020.
